// File: rtl/can_stuff.sv
// CAN transmit bit stuffer: serialises frame bits at CLKS_PER_BIT clocks each and
// inserts a complement stuff bit after five equal bits while stuffing is enabled.
module can_stuff #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Tx_Valid,
    input  logic       i_Tx_Bit,
    input  logic       i_Stuff_En,
    output logic       o_Tx_Ready,
    output logic       o_Tx_Serial,
    output logic       o_Stuff_Active,
    output logic [2:0] o_Run_Count,
    output logic       o_Bit_Done
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, DATA, STUFF} state_t;

    state_t           r_State;
    logic [CNT_W-1:0] r_Clk_Cnt;
    logic             r_Last_Bit;
    logic [2:0]       r_Run;
    logic             r_Stuff_Pend;
    logic             r_Tx_Serial;
    logic             r_Stuff_Active;

    logic             w_Period_End;
    logic             w_Accept;
    logic [2:0]       w_Next_Run;

    assign w_Period_End = (r_State != IDLE) && (r_Clk_Cnt == LAST_CNT);

    // Ready comes only from registered state so the serializer sees no path from its own valid.
    assign o_Tx_Ready = (r_State == IDLE) ||
                        ((r_State == DATA) && w_Period_End && !r_Stuff_Pend) ||
                        ((r_State == STUFF) && w_Period_End);
    assign w_Accept   = i_Tx_Valid & o_Tx_Ready;

    always_comb begin
        w_Next_Run = '0;
        if (!i_Stuff_En)
            w_Next_Run = '0;
        else if ((r_State == IDLE) || (i_Tx_Bit != r_Last_Bit) || (r_Run == '0))
            w_Next_Run = 3'd1;
        else
            w_Next_Run = r_Run + 3'd1;
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_State        <= IDLE;
            r_Clk_Cnt      <= '0;
            r_Last_Bit     <= 1'b1;
            r_Run          <= '0;
            r_Stuff_Pend   <= 1'b0;
            r_Tx_Serial    <= 1'b1;
            r_Stuff_Active <= 1'b0;
        end else if ((r_State != IDLE) && !w_Period_End) begin
            r_Clk_Cnt <= r_Clk_Cnt + CNT_W'(1);
        end else if ((r_State == DATA) && r_Stuff_Pend) begin
            // The stuff bit goes out regardless of i_Tx_Valid and starts the next run.
            r_State        <= STUFF;
            r_Clk_Cnt      <= '0;
            r_Tx_Serial    <= ~r_Last_Bit;
            r_Stuff_Active <= 1'b1;
            r_Run          <= 3'd1;
            r_Last_Bit     <= ~r_Last_Bit;
            r_Stuff_Pend   <= 1'b0;
        end else if (w_Accept) begin
            r_State        <= DATA;
            r_Clk_Cnt      <= '0;
            r_Tx_Serial    <= i_Tx_Bit;
            r_Stuff_Active <= 1'b0;
            r_Run          <= w_Next_Run;
            r_Last_Bit     <= i_Tx_Bit;
            r_Stuff_Pend   <= i_Stuff_En && (w_Next_Run == 3'd5);
        end else begin
            r_State        <= IDLE;
            r_Clk_Cnt      <= '0;
            r_Tx_Serial    <= 1'b1;
            r_Stuff_Active <= 1'b0;
            r_Run          <= '0;
        end
    end

    assign o_Tx_Serial    = r_Tx_Serial;
    assign o_Stuff_Active = r_Stuff_Active;
    assign o_Run_Count    = r_Run;
    assign o_Bit_Done     = w_Period_End;

endmodule

// File: tb/tb_can_stuff.sv
// Directed bench for can_stuff: a reference stuffing model fills a scoreboard of
// expected bit periods that a monitor checks on every o_Bit_Done pulse.
module tb_can_stuff;

    localparam int CLKS = 10;

    logic       clk = 1'b0;
    logic       i_Reset;
    logic       i_Tx_Valid;
    logic       i_Tx_Bit;
    logic       i_Stuff_En;
    logic       o_Tx_Ready;
    logic       o_Tx_Serial;
    logic       o_Stuff_Active;
    logic [2:0] o_Run_Count;
    logic       o_Bit_Done;

    can_stuff #(.CLKS_PER_BIT(CLKS)) dut (
        .i_Clock       (clk),
        .i_Reset       (i_Reset),
        .i_Tx_Valid    (i_Tx_Valid),
        .i_Tx_Bit      (i_Tx_Bit),
        .i_Stuff_En    (i_Stuff_En),
        .o_Tx_Ready    (o_Tx_Ready),
        .o_Tx_Serial   (o_Tx_Serial),
        .o_Stuff_Active(o_Stuff_Active),
        .o_Run_Count   (o_Run_Count),
        .o_Bit_Done    (o_Bit_Done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ser;
        logic       stf;
        logic [2:0] run;
        logic       rdy;
        logic       contig;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   last_done = 0;

    logic       m_idle = 1'b1;
    logic       m_last = 1'b1;
    logic [2:0] m_run  = 3'd0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: one expected entry per bit period, data or stuff.
    always @(negedge clk) begin
        exp_t e;
        if (!i_Reset && o_Bit_Done) begin
            if (q.size() == 0) begin
                chk("unexpected_bit_done", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("serial", {31'd0, o_Tx_Serial}, {31'd0, e.ser});
                chk("stuff_active", {31'd0, o_Stuff_Active}, {31'd0, e.stf});
                chk("run_count", {29'd0, o_Run_Count}, {29'd0, e.run});
                chk("ready_last_clk", {31'd0, o_Tx_Ready}, {31'd0, e.rdy});
                if (e.contig)
                    chk("period_len", 32'(cyc - last_done), 32'(CLKS));
            end
            last_done = cyc;
        end
    end

    task automatic send(input logic b, input logic en);
        int unsigned n;
        logic        stuffing;
        @(negedge clk);
        i_Tx_Valid = 1'b1;
        i_Tx_Bit   = b;
        i_Stuff_En = en;
        n = 0;
        while (!o_Tx_Ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            chk("ready_timeout", 32'd1, 32'd0);
        end else begin
            @(posedge clk);
            if (!en)
                m_run = 3'd0;
            else if (m_idle || b != m_last || m_run == 3'd0)
                m_run = 3'd1;
            else
                m_run = m_run + 3'd1;
            m_last   = b;
            stuffing = en && (m_run == 3'd5);
            q.push_back('{ser: b, stf: 1'b0, run: m_run, rdy: !stuffing, contig: !m_idle});
            if (stuffing) begin
                q.push_back('{ser: ~b, stf: 1'b1, run: 3'd1, rdy: 1'b1, contig: 1'b1});
                m_last = ~b;
                m_run  = 3'd1;
            end
            m_idle = 1'b0;
        end
    endtask

    task automatic end_burst();
        int unsigned n;
        @(negedge clk);
        i_Tx_Valid = 1'b0;
        m_idle     = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(q.size()), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("idle_serial", {31'd0, o_Tx_Serial}, 32'd1);
        chk("idle_ready", {31'd0, o_Tx_Ready}, 32'd1);
        chk("idle_run", {29'd0, o_Run_Count}, 32'd0);
        chk("idle_stuff", {31'd0, o_Stuff_Active}, 32'd0);
    endtask

    initial begin
        int unsigned n;
        i_Reset    = 1'b1;
        i_Tx_Valid = 1'b0;
        i_Tx_Bit   = 1'b1;
        i_Stuff_En = 1'b0;
        #1;
        chk("rst_serial", {31'd0, o_Tx_Serial}, 32'd1);
        chk("rst_stuff", {31'd0, o_Stuff_Active}, 32'd0);
        chk("rst_done", {31'd0, o_Bit_Done}, 32'd0);
        chk("rst_run", {29'd0, o_Run_Count}, 32'd0);
        repeat (3) @(negedge clk);
        i_Reset = 1'b0;
        #1;
        chk("rst_ready", {31'd0, o_Tx_Ready}, 32'd1);

        // Five dominant bits then a recessive stuff bit.
        for (int i = 0; i < 5; i++) send(1'b0, 1'b1);
        end_burst();

        // Alternating bits never stuff.
        for (int i = 0; i < 10; i++) send(1'(i % 2 == 0), 1'b1);
        end_burst();

        // Stuff bit counts as the first of the following run of ones.
        for (int i = 0; i < 5; i++) send(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) send(1'b1, 1'b1);
        end_burst();

        // Stuffing disabled: six recessive bits pass untouched.
        for (int i = 0; i < 6; i++) send(1'b1, 1'b0);
        end_burst();

        // Enable toggles per bit: the fifth equal bit without stuffing clears the run.
        for (int i = 0; i < 4; i++) send(1'b0, 1'b1);
        send(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send(1'b0, 1'b1);
        end_burst();

        // Reset in the fourth clock of a stuff bit.
        for (int i = 0; i < 5; i++) send(1'b0, 1'b1);
        @(negedge clk);
        i_Tx_Valid = 1'b0;
        n = 0;
        while (!o_Stuff_Active && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("stuff_seen", {31'd0, o_Stuff_Active}, 32'd1);
        repeat (3) @(negedge clk);
        i_Reset = 1'b1;
        #1;
        chk("abort_serial", {31'd0, o_Tx_Serial}, 32'd1);
        chk("abort_stuff", {31'd0, o_Stuff_Active}, 32'd0);
        chk("abort_run", {29'd0, o_Run_Count}, 32'd0);
        @(negedge clk);
        i_Reset = 1'b0;
        q.delete();
        m_idle = 1'b1;
        m_run  = 3'd0;
        #1;
        chk("abort_ready", {31'd0, o_Tx_Ready}, 32'd1);
        send(1'b0, 1'b1);
        end_burst();

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
